// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and constants for the MIPS register file.
//   - dbg_state_e      : debug dump engine state (IDLE, DUMP)
//   - DefDataWidth     : default register width in bits
//   - DefAddrWidth     : default address width
//   - depth_of()       : number of registers for a given address width
package reg_file_pkg;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefAddrWidth = 5;

   typedef enum logic {
      IDLE = 1'b0,
      DUMP = 1'b1
   } dbg_state_e;

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/reg_file_dbg_scan.sv
// reg_file_dbg_scan: debug dump sequencer for reg_file.
// Walks an index from 0 to depth-1, one beat per valid/ready handshake, then
// returns to idle. The parent indexes its storage with o_index.
// Ports:
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous active-low reset
//   i_start  : request a full dump (ignored while a dump is running)
//   i_ready  : sink accepts the current beat
//   o_valid  : beat valid
//   o_last   : current beat is the final index
//   o_busy   : dump in progress
//   o_index  : register index of the current beat
module reg_file_dbg_scan
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic                  o_last,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] o_index
);

   localparam int unsigned Depth = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LastIndex = ADDR_WIDTH'(Depth - 1);

   dbg_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] index_q, index_d;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      o_valid = 1'b0;
      o_busy  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = DUMP;
               index_d = '0;
            end
         end
         DUMP: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            if (i_ready) begin
               // Final accept leaves the index parked at depth-1; no wrap.
               if (index_q == LastIndex) begin
                  state_d = IDLE;
               end else begin
                  index_d = index_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_last  = o_valid && (index_q == LastIndex);
   assign o_index = index_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: parametrised MIPS general-purpose register file for the ID stage.
// Two combinational read ports with same-cycle write bypass, one edge-triggered
// write port, optional hardwired-zero register 0, full clear on reset, and a
// handshaked debug engine that streams every register out.
// Ports:
//   i_clock, i_reset           : clock (rising edge), async active-low reset
//   i_regwrite/i_rd/i_writedata: write port from WB
//   i_rs/o_regA, i_rt/o_regB   : read ports A and B
//   i_debug_start              : request a full dump
//   i_debug_ready              : debug sink accepts current beat
//   o_debug_valid/addr/data    : current dump beat
//   o_debug_last               : beat is index depth-1
//   o_debug_busy               : dump in progress
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_regwrite,
   input  logic [ADDR_WIDTH-1:0] i_rd,
   input  logic [DATA_WIDTH-1:0] i_writedata,
   input  logic [ADDR_WIDTH-1:0] i_rs,
   input  logic [ADDR_WIDTH-1:0] i_rt,
   output logic [DATA_WIDTH-1:0] o_regA,
   output logic [DATA_WIDTH-1:0] o_regB,
   input  logic                  i_debug_start,
   input  logic                  i_debug_ready,
   output logic                  o_debug_valid,
   output logic [ADDR_WIDTH-1:0] o_debug_addr,
   output logic [DATA_WIDTH-1:0] o_debug_data,
   output logic                  o_debug_last,
   output logic                  o_debug_busy
);

   localparam int unsigned Depth  = depth_of(ADDR_WIDTH);
   localparam bit          ZeroEn = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] dbg_index;

   // Writes to r0 are dropped when it is hardwired to zero.
   assign wr_en = i_regwrite && !(ZeroEn && (i_rd == '0));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[i_rd] <= i_writedata;
      end
   end

   // Zero check takes priority over bypass so a dropped r0 write never leaks.
   always_comb begin
      if (ZeroEn && (i_rs == '0)) begin
         o_regA = '0;
      end else if (i_regwrite && (i_rd == i_rs)) begin
         o_regA = i_writedata;
      end else begin
         o_regA = mem_q[i_rs];
      end
   end

   always_comb begin
      if (ZeroEn && (i_rt == '0)) begin
         o_regB = '0;
      end else if (i_regwrite && (i_rd == i_rt)) begin
         o_regB = i_writedata;
      end else begin
         o_regB = mem_q[i_rt];
      end
   end

   reg_file_dbg_scan #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dbg_scan (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_start (i_debug_start),
      .i_ready (i_debug_ready),
      .o_valid (o_debug_valid),
      .o_last  (o_debug_last),
      .o_busy  (o_debug_busy),
      .o_index (dbg_index)
   );

   // Dump shows committed storage only; a stalled beat follows live contents.
   assign o_debug_addr = dbg_index;
   assign o_debug_data = (ZeroEn && (dbg_index == '0)) ? '0 : mem_q[dbg_index];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file with a scoreboard of expected
// read results and expected debug beats.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        regwrite;
   logic [4:0]  rd;
   logic [31:0] wdata;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        dbg_start;
   logic        dbg_ready;

   logic [31:0] rega, regb;
   logic        dbg_valid, dbg_last, dbg_busy;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   logic [31:0] rega_nz, regb_nz;
   logic        dbg_valid_nz, dbg_last_nz, dbg_busy_nz;
   logic [4:0]  dbg_addr_nz;
   logic [31:0] dbg_data_nz;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] rd_q[$];

   reg_file #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .ZERO_REG   (1)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_regwrite    (regwrite),
      .i_rd          (rd),
      .i_writedata   (wdata),
      .i_rs          (rs),
      .i_rt          (rt),
      .o_regA        (rega),
      .o_regB        (regb),
      .i_debug_start (dbg_start),
      .i_debug_ready (dbg_ready),
      .o_debug_valid (dbg_valid),
      .o_debug_addr  (dbg_addr),
      .o_debug_data  (dbg_data),
      .o_debug_last  (dbg_last),
      .o_debug_busy  (dbg_busy)
   );

   reg_file #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .ZERO_REG   (0)
   ) dut_nz (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_regwrite    (regwrite),
      .i_rd          (rd),
      .i_writedata   (wdata),
      .i_rs          (rs),
      .i_rt          (rt),
      .o_regA        (rega_nz),
      .o_regB        (regb_nz),
      .i_debug_start (dbg_start),
      .i_debug_ready (dbg_ready),
      .o_debug_valid (dbg_valid_nz),
      .o_debug_addr  (dbg_addr_nz),
      .o_debug_data  (dbg_data_nz),
      .o_debug_last  (dbg_last_nz),
      .o_debug_busy  (dbg_busy_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive both read addresses, queue expectations, sample combinationally.
   task automatic rd_chk(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] ea, input logic [31:0] eb, input string tag);
      rs = a;
      rt = b;
      rd_q.push_back(ea);
      rd_q.push_back(eb);
      #1;
      check({tag, "_A"}, rega, rd_q.pop_front());
      check({tag, "_B"}, regb, rd_q.pop_front());
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      regwrite = 1'b1;
      rd       = a;
      wdata    = d;
      @(posedge clk);
      #1;
      regwrite = 1'b0;
   endtask

   task automatic pulse_start();
      dbg_start = 1'b1;
      @(posedge clk);
      #1;
      dbg_start = 1'b0;
   endtask

   // kind 0: r[i]=i*3; kind 1: same with r7=0xAA; kind 2: all zero. r0 is 0 in all.
   task automatic push_dump(input int kind);
      beat_t b;
      for (int i = 0; i < 32; i++) begin
         b.addr = 5'(i);
         b.data = (kind == 2) ? 32'd0 : 32'(i * 3);
         if (kind == 1 && i == 7) b.data = 32'hAA;
         b.last = (i == 31);
         exp_q.push_back(b);
      end
   endtask

   // Entered just after a rising edge. mode 0: ready held high; mode 1: ready
   // on every third cycle, start re-pulsed mid-dump, r7 written while stalled.
   // stop_at >= 0 returns at the falling edge where that index is first valid.
   task automatic drain(input int mode, input int stop_at, output bit stopped);
      beat_t b;
      int    c;
      bit    wrote;
      c       = 0;
      wrote   = 1'b0;
      stopped = 1'b0;
      while (exp_q.size() != 0 && c < 400) begin
         regwrite  = 1'b0;
         dbg_start = (mode == 1 && c == 5);
         dbg_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
         @(negedge clk);
         if (c == 0) begin
            check("first_beat_valid", 32'(dbg_valid), 32'd1);
            check("first_beat_addr", 32'(dbg_addr), 32'd0);
         end
         if (stop_at >= 0 && dbg_valid && dbg_addr == 5'(stop_at)) begin
            stopped = 1'b1;
            return;
         end
         if (dbg_valid && dbg_ready) begin
            b = exp_q.pop_front();
            check($sformatf("beat%0d_addr", b.addr), 32'(dbg_addr), 32'(b.addr));
            check($sformatf("beat%0d_data", b.addr), dbg_data, b.data);
            check($sformatf("beat%0d_last", b.addr), 32'(dbg_last), 32'(b.last));
            check($sformatf("beat%0d_busy", b.addr), 32'(dbg_busy), 32'd1);
            check($sformatf("beat%0d_nz_addr", b.addr), 32'(dbg_addr_nz), 32'(b.addr));
            check($sformatf("beat%0d_nz_data", b.addr), dbg_data_nz, b.data);
            check($sformatf("beat%0d_nz_last", b.addr), 32'(dbg_last_nz), 32'(b.last));
            check($sformatf("beat%0d_nz_valid", b.addr), 32'(dbg_valid_nz), 32'd1);
            check($sformatf("beat%0d_nz_busy", b.addr), 32'(dbg_busy_nz), 32'd1);
         end else if (mode == 1 && dbg_valid && dbg_addr == 5'd7 && !wrote) begin
            regwrite = 1'b1;
            rd       = 5'd7;
            wdata    = 32'hAA;
            wrote    = 1'b1;
         end
         c++;
         @(posedge clk);
         #1;
      end
      regwrite  = 1'b0;
      dbg_start = 1'b0;
      check("dump_beats_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(dbg_valid), 32'd0);
      check({tag, "_busy"}, 32'(dbg_busy), 32'd0);
      check({tag, "_last"}, 32'(dbg_last), 32'd0);
   endtask

   initial begin
      bit stopped;
      rst_n     = 1'b0;
      regwrite  = 1'b0;
      rd        = '0;
      wdata     = '0;
      rs        = '0;
      rt        = '0;
      dbg_start = 1'b0;
      dbg_ready = 1'b0;

      // Reset state: debug idle, every register reads zero on both ports.
      #2;
      check_idle("reset");
      check("reset_addr", 32'(dbg_addr), 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd_chk(5'(i), 5'(31 - i), 32'd0, 32'd0, $sformatf("reset_r%0d", i));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Same-cycle bypass, then committed value.
      regwrite = 1'b1;
      rd       = 5'd5;
      wdata    = 32'hDEADBEEF;
      rd_chk(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, "bypass_r5");
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      rd_chk(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "commit_r5");

      // r0 write: hardwired instance drops it, ordinary instance keeps it.
      regwrite = 1'b1;
      rd       = 5'd0;
      wdata    = 32'h1234;
      rd_chk(5'd0, 5'd0, 32'd0, 32'd0, "zero_bypass");
      check("nz_bypass_r0", rega_nz, 32'h1234);
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      rd_chk(5'd0, 5'd5, 32'd0, 32'hDEADBEEF, "zero_commit");
      check("nz_commit_r0_A", rega_nz, 32'h1234);
      check("nz_commit_r0_B", regb_nz, 32'hDEADBEEF);

      // Preload and full-rate dump.
      for (int i = 0; i < 32; i++) begin
         wr(5'(i), 32'(i * 3));
      end
      rd_chk(5'd9, 5'd31, 32'd27, 32'd93, "preload");
      push_dump(0);
      pulse_start();
      drain(0, -1, stopped);
      dbg_ready = 1'b0;
      @(negedge clk);
      check_idle("after_dump0");
      @(posedge clk);
      #1;

      // Throttled dump with a stalled-beat write and an ignored start.
      push_dump(1);
      pulse_start();
      drain(1, -1, stopped);
      dbg_ready = 1'b0;
      @(negedge clk);
      check_idle("after_dump1");
      rd_chk(5'd7, 5'd6, 32'hAA, 32'd18, "r7_after_stall_write");

      // Reset in the middle of a dump.
      @(posedge clk);
      #1;
      push_dump(1);
      pulse_start();
      drain(0, 10, stopped);
      check("reached_beat10", 32'(stopped), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle("midreset");
      check("midreset_addr", 32'(dbg_addr), 32'd0);
      exp_q.delete();
      rd_chk(5'd7, 5'd31, 32'd0, 32'd0, "midreset_r7_r31");
      rd_chk(5'd5, 5'd10, 32'd0, 32'd0, "midreset_r5_r10");
      check("midreset_nz_r5", rega_nz, 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_dump(2);
      pulse_start();
      drain(0, -1, stopped);
      dbg_ready = 1'b0;
      @(negedge clk);
      check_idle("after_dump2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
